// File: rtl/neuron_feeder.sv
// neuron_feeder: streams N input/weight pairs from two RAMs into one neuron and captures its result
module neuron_feeder #(
  parameter int N_INPUTS = 16,
  parameter int ADDR_W   = 10,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       bias_in,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [15:0]       in_rdata,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [15:0]       w_rdata,
  output logic [15:0]       inp_data,
  output logic [15:0]       weight,
  output logic [15:0]       bias,
  output logic              inp_ready,
  input  logic              out_ready,
  input  logic [15:0]       out,
  output logic [15:0]       result,
  output logic              done,
  output logic              error,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic rd_valid, accept, last, cap, tmo;
  assign w_addr = in_addr;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state: DRAIN waits until the last pair has left the read pipeline
  always_comb begin
    state_nx = accept ? STREAM
             : last ? DRAIN
             : (state == DRAIN && !rd_valid && !inp_ready) ? WAIT
             : (cap || tmo) ? IDLE
             : state;
  end
  // control decode; out_ready beats a same-cycle timeout
  always_comb begin
    accept = state == IDLE && start;
    last   = state == STREAM && in_addr == ADDR_W'(N_INPUTS - 1);
    cap    = state == WAIT && out_ready;
    tmo    = state == WAIT && !out_ready && cnt == CW'(TIMEOUT - 1);
    busy   = state != IDLE;
  end
  // address generation, read pipeline and result capture
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_addr   <= '0;
      rd_valid  <= 1'b0;
      inp_ready <= 1'b0;
      inp_data  <= '0;
      weight    <= '0;
      bias      <= '0;
      error     <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      cnt       <= '0;
    end else begin
      in_addr   <= accept ? '0 : (state == STREAM && !last) ? in_addr + 1'b1 : in_addr;
      rd_valid  <= state == STREAM;
      inp_ready <= rd_valid;
      inp_data  <= rd_valid ? in_rdata : '0;
      weight    <= rd_valid ? w_rdata : '0;
      bias      <= accept ? bias_in : bias;
      error     <= accept ? 1'b0 : tmo ? 1'b1 : error;
      result    <= cap ? out : tmo ? '0 : result;
      done      <= cap || tmo;
      cnt       <= state == WAIT ? cnt + 1'b1 : '0;
    end
endmodule
